// File: rtl/nes_cpu_pkg.sv
// Shared encodings for the NES CPU decode path: addressing modes, instruction types,
// decode FSM states, the packed decode-to-execute word and the opcode table entry.
package nes_cpu_pkg;

    typedef enum logic [3:0] {
        MODE_NONE = 4'd0,
        MODE_ACC  = 4'd1,
        MODE_IMM  = 4'd2,
        MODE_ABS  = 4'd3,
        MODE_ZP   = 4'd4,
        MODE_ZPX  = 4'd5,
        MODE_ABSX = 4'd6,
        MODE_IMP  = 4'd7,
        MODE_REL  = 4'd8,
        MODE_INDX = 4'd9,
        MODE_INDY = 4'd10,
        MODE_IND  = 4'd11,
        MODE_ZPY  = 4'd12,
        MODE_ABSY = 4'd13
    } mode_e;

    typedef enum logic [5:0] {
        INS_NONE = 6'd0,
        INS_ADC  = 6'd1,
        INS_AND  = 6'd2,
        INS_ASL  = 6'd3,
        INS_BCC  = 6'd4,
        INS_BCS  = 6'd5,
        INS_BEQ  = 6'd6,
        INS_BMI  = 6'd8,
        INS_BNE  = 6'd9,
        INS_BPL  = 6'd10,
        INS_BVC  = 6'd12,
        INS_BVS  = 6'd13,
        INS_EOR  = 6'd24,
        INS_JSR  = 6'd29,
        INS_LDA  = 6'd30,
        INS_LDY  = 6'd32,
        INS_ORA  = 6'd35,
        INS_STA  = 6'd48
    } instr_e;

    typedef enum logic [2:0] {
        S_OPC   = 3'd0,
        S_OP1   = 3'd1,
        S_OP2   = 3'd2,
        S_ISSUE = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    // Field order matches the execute-side bit layout, MSB first.
    typedef struct packed {
        instr_e      instr;   // [44:39]
        logic        valid;   // [38]
        logic [1:0]  size;    // [37:36]
        mode_e       mode;    // [35:32]
        logic [15:0] pc;      // [31:16]
        logic [7:0]  msb;     // [15:8]
        logic [7:0]  lsb;     // [7:0]
    } d_to_e_t;

    localparam int D2E_WIDTH     = 45;
    localparam int D2E_VALID_BIT = 38;

    typedef struct packed {
        logic        known;
        instr_e      instr;
        mode_e       mode;
        logic [1:0]  size;
    } lut_t;

    function automatic lut_t lut_entry(input instr_e instr, input mode_e mode,
                                       input logic [1:0] size);
        lut_t e;
        e.known = 1'b1;
        e.instr = instr;
        e.mode  = mode;
        e.size  = size;
        return e;
    endfunction

    function automatic instr_e alu_group_instr(input logic [2:0] aaa);
        instr_e i;
        case (aaa)
            3'd0:    i = INS_ORA;
            3'd1:    i = INS_AND;
            3'd2:    i = INS_EOR;
            3'd3:    i = INS_ADC;
            3'd4:    i = INS_STA;
            3'd5:    i = INS_LDA;
            default: i = INS_NONE;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake bundle for decode_stage; slave is the decoder's view.
interface decode_stage_if;
    logic        f_valid;
    logic [7:0]  f_byte;
    logic [15:0] f_pc;
    logic        d_ready;
    logic        halt_f_to_d;
    logic        halt_d_to_e;
    logic        flush_f_to_d;
    logic [44:0] d_to_e_reg;
    logic        illegal_op;

    modport master (
        output f_valid, f_byte, f_pc, halt_f_to_d, halt_d_to_e, flush_f_to_d,
        input  d_ready, d_to_e_reg, illegal_op
    );

    modport slave (
        input  f_valid, f_byte, f_pc, halt_f_to_d, halt_d_to_e, flush_f_to_d,
        output d_ready, d_to_e_reg, illegal_op
    );
endinterface

// File: rtl/opcode_lut.sv
// Combinational 6502 opcode table: opcode -> {known, type, mode, size}.
// The cc=01 ALU group is decoded by field; the rest are listed individually.
module opcode_lut
    import nes_cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output lut_t       entry
);

    logic [2:0] aaa_s;
    logic [2:0] bbb_s;
    logic       alu_ok_s;

    assign aaa_s    = opcode[7:5];
    assign bbb_s    = opcode[4:2];
    // 0x89 would be STA immediate, which does not exist.
    assign alu_ok_s = (opcode[1:0] == 2'b01) && (aaa_s <= 3'd5) && (opcode != 8'h89);

    // Table lookup.
    always_comb begin
        entry      = '0;
        entry.size = 2'd1;
        if (alu_ok_s) begin
            case (bbb_s)
                3'd0:    entry = lut_entry(alu_group_instr(aaa_s), MODE_INDX, 2'd2);
                3'd1:    entry = lut_entry(alu_group_instr(aaa_s), MODE_ZP,   2'd2);
                3'd2:    entry = lut_entry(alu_group_instr(aaa_s), MODE_IMM,  2'd2);
                3'd3:    entry = lut_entry(alu_group_instr(aaa_s), MODE_ABS,  2'd3);
                3'd4:    entry = lut_entry(alu_group_instr(aaa_s), MODE_INDY, 2'd2);
                3'd5:    entry = lut_entry(alu_group_instr(aaa_s), MODE_ZPX,  2'd2);
                3'd6:    entry = lut_entry(alu_group_instr(aaa_s), MODE_ABSY, 2'd3);
                3'd7:    entry = lut_entry(alu_group_instr(aaa_s), MODE_ABSX, 2'd3);
                default: entry = '0;
            endcase
        end else begin
            case (opcode)
                8'h0A:   entry = lut_entry(INS_ASL, MODE_ACC,  2'd1);
                8'h06:   entry = lut_entry(INS_ASL, MODE_ZP,   2'd2);
                8'h16:   entry = lut_entry(INS_ASL, MODE_ZPX,  2'd2);
                8'h0E:   entry = lut_entry(INS_ASL, MODE_ABS,  2'd3);
                8'h1E:   entry = lut_entry(INS_ASL, MODE_ABSX, 2'd3);
                8'h20:   entry = lut_entry(INS_JSR, MODE_ABS,  2'd3);
                8'hA0:   entry = lut_entry(INS_LDY, MODE_IMM,  2'd2);
                8'hA4:   entry = lut_entry(INS_LDY, MODE_ZP,   2'd2);
                8'hB4:   entry = lut_entry(INS_LDY, MODE_ZPX,  2'd2);
                8'hAC:   entry = lut_entry(INS_LDY, MODE_ABS,  2'd3);
                8'hBC:   entry = lut_entry(INS_LDY, MODE_ABSX, 2'd3);
                8'h10:   entry = lut_entry(INS_BPL, MODE_REL,  2'd2);
                8'h30:   entry = lut_entry(INS_BMI, MODE_REL,  2'd2);
                8'h50:   entry = lut_entry(INS_BVC, MODE_REL,  2'd2);
                8'h70:   entry = lut_entry(INS_BVS, MODE_REL,  2'd2);
                8'h90:   entry = lut_entry(INS_BCC, MODE_REL,  2'd2);
                8'hB0:   entry = lut_entry(INS_BCS, MODE_REL,  2'd2);
                8'hD0:   entry = lut_entry(INS_BNE, MODE_REL,  2'd2);
                8'hF0:   entry = lut_entry(INS_BEQ, MODE_REL,  2'd2);
                default: entry = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: collects opcode + operand bytes and issues one d_to_e word per instruction.
// Build option DECODE_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal_op) instead of NOP.
module decode_stage
    import nes_cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    state_e     state_r;
    state_e     state_next_s;
    d_to_e_t    word_r;
    lut_t       lut_s;
    instr_e     dec_instr_s;
    mode_e      dec_mode_s;
    logic [1:0] dec_size_s;
    logic       trap_s;
    logic       illegal_s;
    logic       ready_s;
    logic       xfer_s;

    opcode_lut u_lut (
        .opcode (bus.f_byte),
        .entry  (lut_s)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_r;

    assign dec_instr_s = lut_s.instr;
    assign dec_mode_s  = lut_s.mode;
    assign dec_size_s  = lut_s.size;
    assign trap_s      = xfer_s && (state_r == S_OPC) && !lut_s.known;
    assign illegal_s   = illegal_r;

    // Sticky trap flag, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (bus.flush_f_to_d) begin
            illegal_r <= 1'b0;
        end else if (trap_s) begin
            illegal_r <= 1'b1;
        end
    end
`else
    // Unknown opcodes become a one-byte implied NOP (type 0).
    assign dec_instr_s = lut_s.known ? lut_s.instr : INS_NONE;
    assign dec_mode_s  = lut_s.known ? lut_s.mode  : MODE_IMP;
    assign dec_size_s  = lut_s.known ? lut_s.size  : 2'd1;
    assign trap_s      = 1'b0;
    assign illegal_s   = 1'b0;
`endif

    assign ready_s = rst_n && (state_r inside {S_OPC, S_OP1, S_OP2}) &&
                     !bus.halt_f_to_d && !bus.flush_f_to_d && !illegal_s;
    assign xfer_s  = bus.f_valid && ready_s;

    assign bus.d_ready    = ready_s;
    assign bus.d_to_e_reg = word_r;
    assign bus.illegal_op = illegal_s;

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (bus.flush_f_to_d) begin
            state_next_s = S_OPC;
        end else begin
            case (state_r)
                S_OPC: begin
                    if (xfer_s && !trap_s) begin
                        state_next_s = (dec_size_s == 2'd1) ? S_ISSUE : S_OP1;
                    end else begin
                        state_next_s = S_OPC;
                    end
                end
                S_OP1: begin
                    if (xfer_s) begin
                        state_next_s = (word_r.size == 2'd2) ? S_ISSUE : S_OP2;
                    end else begin
                        state_next_s = S_OP1;
                    end
                end
                S_OP2: begin
                    if (xfer_s) begin
                        state_next_s = S_ISSUE;
                    end else begin
                        state_next_s = S_OP2;
                    end
                end
                S_ISSUE: begin
                    if (bus.halt_d_to_e) begin
                        state_next_s = S_ISSUE;
                    end else begin
                        state_next_s = S_GAP;
                    end
                end
                S_GAP:   state_next_s = S_OPC;
                default: state_next_s = S_OPC;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_OPC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output word: valid follows the ISSUE state, fields load as bytes arrive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_r <= '0;
        end else begin
            word_r.valid <= (state_next_s == S_ISSUE);
            if (xfer_s) begin
                case (state_r)
                    S_OPC: begin
                        if (!trap_s) begin
                            word_r.instr <= dec_instr_s;
                            word_r.mode  <= dec_mode_s;
                            word_r.size  <= dec_size_s;
                            word_r.pc    <= bus.f_pc;
                            word_r.msb   <= 8'h00;
                            word_r.lsb   <= 8'h00;
                        end
                    end
                    S_OP1:   word_r.lsb <= bus.f_byte;
                    S_OP2:   word_r.msb <= bus.f_byte;
                    default: word_r.lsb <= word_r.lsb;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected words are built from the
// documented bit layout. Honours DECODE_ILLEGAL_TRAP_EN for the unknown-opcode case.
module tb_decode_stage;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] w(input logic [5:0] t, input logic v, input logic [1:0] sz,
                                      input logic [3:0] md, input logic [15:0] pc,
                                      input logic [7:0] msb, input logic [7:0] lsb);
        return {t, v, sz, md, pc, msb, lsb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and wait (bounded) until it is accepted.
    task automatic send(input logic [7:0] b, input logic [15:0] pc);
        int n;
        bus.f_valid = 1'b1;
        bus.f_byte  = b;
        bus.f_pc    = pc;
        #1;
        n = 0;
        while (!bus.d_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            check("send_timeout", 64'd0, 64'd1);
        end
        step();
        bus.f_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.f_valid = 1'b0;
        bus.f_byte = 8'h00;
        bus.f_pc = 16'h0000;
        bus.halt_f_to_d = 1'b0;
        bus.halt_d_to_e = 1'b0;
        bus.flush_f_to_d = 1'b0;
        step();
        step();
        check("rst_word", 64'(bus.d_to_e_reg), 64'd0);
        check("rst_ready", 64'(bus.d_ready), 64'd0);
        check("rst_illegal", 64'(bus.illegal_op), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.d_ready), 64'd1);

        // 1: LDA #05
        send(8'hA9, 16'h8000);
        check("lda_wait_valid", 64'(bus.d_to_e_reg[38]), 64'd0);
        send(8'h05, 16'h8001);
        check("lda_word", 64'(bus.d_to_e_reg), 64'(w(6'd30, 1'b1, 2'd2, 4'd2, 16'h8000, 8'h00, 8'h05)));
        step();
        check("lda_gap", 64'(bus.d_to_e_reg), 64'(w(6'd30, 1'b0, 2'd2, 4'd2, 16'h8000, 8'h00, 8'h05)));
        step();

        // 2: JSR $1234 held by halt_d_to_e
        bus.halt_d_to_e = 1'b1;
        send(8'h20, 16'h8010);
        send(8'h34, 16'h8011);
        send(8'h12, 16'h8012);
        check("jsr_word", 64'(bus.d_to_e_reg), 64'(w(6'd29, 1'b1, 2'd3, 4'd3, 16'h8010, 8'h12, 8'h34)));
        step();
        check("jsr_hold2", 64'(bus.d_to_e_reg), 64'(w(6'd29, 1'b1, 2'd3, 4'd3, 16'h8010, 8'h12, 8'h34)));
        step();
        check("jsr_hold3", 64'(bus.d_to_e_reg), 64'(w(6'd29, 1'b1, 2'd3, 4'd3, 16'h8010, 8'h12, 8'h34)));
        bus.halt_d_to_e = 1'b0;
        step();
        check("jsr_gap", 64'(bus.d_to_e_reg[38]), 64'd0);
        step();

        // 3: ASL A then LDA #01 back-to-back
        send(8'h0A, 16'h8020);
        check("asl_word", 64'(bus.d_to_e_reg), 64'(w(6'd3, 1'b1, 2'd1, 4'd1, 16'h8020, 8'h00, 8'h00)));
        bus.f_valid = 1'b1;
        bus.f_byte = 8'hA9;
        bus.f_pc = 16'h8021;
        #1;
        check("asl_issue_ready", 64'(bus.d_ready), 64'd0);
        step();
        check("asl_gap_valid", 64'(bus.d_to_e_reg[38]), 64'd0);
        check("asl_gap_ready", 64'(bus.d_ready), 64'd0);
        send(8'hA9, 16'h8021);
        send(8'h01, 16'h8022);
        check("lda2_word", 64'(bus.d_to_e_reg), 64'(w(6'd30, 1'b1, 2'd2, 4'd2, 16'h8021, 8'h00, 8'h01)));
        step();
        step();

        // 4: LDA abs flushed before MSB; F0 decoded as BEQ opcode
        send(8'hAD, 16'h8030);
        send(8'h00, 16'h8031);
        bus.flush_f_to_d = 1'b1;
        bus.f_valid = 1'b1;
        bus.f_byte = 8'hF0;
        bus.f_pc = 16'h8032;
        #1;
        check("flush_ready", 64'(bus.d_ready), 64'd0);
        step();
        bus.flush_f_to_d = 1'b0;
        bus.f_valid = 1'b0;
        check("flush_word", 64'(bus.d_to_e_reg), 64'(w(6'd30, 1'b0, 2'd3, 4'd3, 16'h8030, 8'h00, 8'h00)));
        send(8'hF0, 16'h8040);
        send(8'hFC, 16'h8041);
        check("beq_word", 64'(bus.d_to_e_reg), 64'(w(6'd6, 1'b1, 2'd2, 4'd8, 16'h8040, 8'h00, 8'hFC)));
        step();
        step();

        // 5: STA zp with halt_f_to_d between bytes
        send(8'h85, 16'h8050);
        bus.halt_f_to_d = 1'b1;
        bus.f_valid = 1'b1;
        bus.f_byte = 8'h10;
        bus.f_pc = 16'h8051;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("halt_ready", 64'(bus.d_ready), 64'd0);
            step();
            check("halt_valid", 64'(bus.d_to_e_reg[38]), 64'd0);
        end
        bus.halt_f_to_d = 1'b0;
        send(8'h10, 16'h8051);
        check("sta_word", 64'(bus.d_to_e_reg), 64'(w(6'd48, 1'b1, 2'd2, 4'd4, 16'h8050, 8'h00, 8'h10)));
        step();
        step();

        // ALU-group decode: ADC (zp),Y
        send(8'h71, 16'h8090);
        send(8'h44, 16'h8091);
        check("adc_indy_word", 64'(bus.d_to_e_reg), 64'(w(6'd1, 1'b1, 2'd2, 4'd10, 16'h8090, 8'h00, 8'h44)));
        step();
        step();

        // 6: unknown opcode 02
        send(8'h02, 16'h8060);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("trap_flag", 64'(bus.illegal_op), 64'd1);
        check("trap_ready", 64'(bus.d_ready), 64'd0);
        check("trap_valid", 64'(bus.d_to_e_reg[38]), 64'd0);
        step();
        step();
        check("trap_sticky", 64'(bus.illegal_op), 64'd1);
        bus.flush_f_to_d = 1'b1;
        step();
        bus.flush_f_to_d = 1'b0;
        #1;
        check("trap_clear", 64'(bus.illegal_op), 64'd0);
        check("trap_ready_back", 64'(bus.d_ready), 64'd1);
`else
        check("nop_word", 64'(bus.d_to_e_reg), 64'(w(6'd0, 1'b1, 2'd1, 4'd7, 16'h8060, 8'h00, 8'h00)));
        check("nop_illegal", 64'(bus.illegal_op), 64'd0);
        step();
        step();
`endif

        // Reset mid-instruction
        send(8'hA9, 16'h8070);
        rst_n = 1'b0;
        step();
        check("mid_rst_word", 64'(bus.d_to_e_reg), 64'd0);
        check("mid_rst_ready", 64'(bus.d_ready), 64'd0);
        rst_n = 1'b1;
        send(8'h0A, 16'h8080);
        check("post_rst_asl", 64'(bus.d_to_e_reg), 64'(w(6'd3, 1'b1, 2'd1, 4'd1, 16'h8080, 8'h00, 8'h00)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
